// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/accumulate (pipelined) and radix-2 restoring divide unit.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3;
    localparam int CW = $clog2(WIDTH + MUL_STAGES) + 1;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] pipe [MUL_STAGES];
    logic [WIDTH-1:0]   quo, rem, dvs, a_org;
    logic               q_neg, r_neg, dz;
    logic               mul_op, div_op, launch, a_neg, b_neg;
    logic [2*WIDTH-1:0] ea, eb, prod, acc, mres;
    logic [WIDTH:0]     sh, diff;

    always_comb begin
        mul_op = !func[3] && func[3:1] != 3'd1;
        div_op = func[3:1] == 3'd1;
        launch = start && !busy && !flush && (mul_op || div_op);
        ea     = {{WIDTH{!func[0] && a[WIDTH-1]}}, a};
        eb     = {{WIDTH{!func[0] && b[WIDTH-1]}}, b};
        prod   = ea * eb;
        acc    = {hi_in, lo_in};
        mres   = func[2] ? (func[1] ? acc - prod : acc + prod) : prod;
        a_neg  = !func[0] && a[WIDTH-1];
        b_neg  = !func[0] && b[WIDTH-1];
        sh     = {rem, quo[WIDTH-1]};
        diff   = sh - {1'b0, dvs};
    end

    // The product is formed from the live operands at the start edge, so pipe[k] holds it in cycle k+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            a_org <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            dz    <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
        end else begin
            done <= 1'b0;
            if (launch) pipe[0] <= mres;
            for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
            if (flush && state != IDLE) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                busy <= launch;
                if (launch) begin
                    state <= div_op ? DIV : MUL;
                    cnt   <= '0;
                    quo   <= a_neg ? -a : a;
                    dvs   <= b_neg ? -b : b;
                    rem   <= '0;
                    a_org <= a;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    dz    <= b == '0;
                end
            end else if (state == MUL) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(MUL_STAGES - 1)) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    {hi, lo} <= pipe[MUL_STAGES-1];
                end
            end else if (state == DIV) begin
                cnt   <= cnt + 1'b1;
                rem   <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo   <= {quo[WIDTH-2:0], !diff[WIDTH]};
                state <= cnt == CW'(WIDTH - 1) ? FIX : DIV;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                hi    <= dz ? a_org : (r_neg ? -rem : rem);
                lo    <= dz ? '1 : (q_neg ? -quo : quo);
            end
        end
    end
endmodule
